uart_tx_sequencer: RTL and testbench

- Byte-queue controller that sequences the UART transmitter (uarttx) on behalf of the CPU.
- Software pushes bytes through the peripheral bus into a FIFO. The block hands bytes one at a time to the transmitter, holds tx_en across the clk/uart_clk boundary, and waits for each frame to complete.
- It sits between the peripheral register decode (clk domain) and uarttx (uart_clk domain). It replaces single-byte polling of the sent flag.

---
 rtl/uart_tx_sequencer.sv | 149 ++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: byte FIFO that feeds uarttx one frame at a time and waits for each frame to finish
`timescale 1ns/1ps
module uart_tx_sequencer #(
    parameter int DEPTH         = 16,
    parameter int ADDR_W        = 4,
    parameter int START_TIMEOUT = 4096,
    parameter int GAP_CYCLES    = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            push,
    input  logic [7:0]      push_data,
    input  logic            flush,
    input  logic            clr_err,
    input  logic            tx_status,
    output logic            tx_en,
    output logic [7:0]      tx_data,
    output logic            full,
    output logic            empty,
    output logic [ADDR_W:0] count,
    output logic            busy,
    output logic            sent_pulse,
    output logic            overflow,
    output logic            timeout_err
);
    localparam int CW = ADDR_W + 1;
    localparam int TW = $clog2(START_TIMEOUT) + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_IDLE, GAP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              tx_en_q, tx_en_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              sync1_q, sts_q;
    logic              sent_q, sent_d;
    logic              overflow_q, overflow_d;
    logic              timeout_q, timeout_d;
    logic [7:0]        mem_q [DEPTH];
    logic              pop, push_ok, to_set;

    assign full        = count_q == FULL_CNT;
    assign empty       = count_q == '0;
    assign count       = count_q;
    assign busy        = state_q != IDLE;
    assign tx_en       = tx_en_q;
    assign tx_data     = tx_data_q;
    assign sent_pulse  = sent_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_q;

    // Frame sequencing plus FIFO pointer/count bookkeeping; flush beats push and blocks a pop
    always_comb begin
        state_d   = state_q;
        tx_en_d   = tx_en_q;
        tx_data_d = tx_data_q;
        timer_d   = timer_q;
        gap_d     = gap_q;
        sent_d    = 1'b0;
        pop       = 1'b0;
        to_set    = 1'b0;
        push_ok   = push && !full && !flush;
        case (state_q)
            IDLE: begin
                if (enable && !empty && !flush) begin
                    pop       = 1'b1;
                    tx_data_d = mem_q[rd_ptr_q];
                    tx_en_d   = 1'b1;
                    timer_d   = '0;
                    state_d   = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                timer_d = timer_q + TW'(1);
                if (sts_q) begin
                    tx_en_d = 1'b0;
                    state_d = WAIT_IDLE;
                end else if (timer_q == T_LAST) begin
                    tx_en_d = 1'b0;
                    to_set  = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!sts_q) begin
                    sent_d  = 1'b1;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                gap_d   = gap_q + GW'(1);
                state_d = (gap_q == G_LAST) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
        wr_ptr_d   = wr_ptr_q + ADDR_W'(push_ok);
        rd_ptr_d   = flush ? wr_ptr_q : rd_ptr_q + ADDR_W'(pop);
        count_d    = flush ? '0 : count_q + CW'(push_ok) - CW'(pop);
        overflow_d = (push && full && !flush) || (overflow_q && !clr_err);
        timeout_d  = to_set || (timeout_q && !clr_err);
    end

    // State, pointers, flags and the tx_status synchronizer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_en_q    <= 1'b0;
            tx_data_q  <= '0;
            timer_q    <= '0;
            gap_q      <= '0;
            sync1_q    <= 1'b0;
            sts_q      <= 1'b0;
            sent_q     <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_en_q    <= tx_en_d;
            tx_data_q  <= tx_data_d;
            timer_q    <= timer_d;
            gap_q      <= gap_d;
            sync1_q    <= tx_status;
            sts_q      <= sync1_q;
            sent_q     <= sent_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    // Byte storage; contents need no reset since pointers and count define validity
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb_uart_tx_sequencer: directed and randomized checks of uart_tx_sequencer against a queue-based reference
`timescale 1ns/1ps
module tb_uart_tx_sequencer;
    localparam int DEPTH = 16;
    localparam int ADDR_W = 4;
    localparam int TO = 8;
    localparam int GAP = 5;

    logic clk = 0, reset = 1, enable = 0, push = 0, flush = 0, clr_err = 0, tx_status = 0;
    logic [7:0] push_data = 0;
    logic tx_en, full, empty, busy, sent_pulse, overflow, timeout_err;
    logic [7:0] tx_data;
    logic [ADDR_W:0] count;
    int errors = 0, checks = 0;
    bit chk_on = 0;
    bit stuck = 0;

    always #5 clk = ~clk;

    uart_tx_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .START_TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .enable(enable), .push(push), .push_data(push_data),
        .flush(flush), .clr_err(clr_err), .tx_status(tx_status), .tx_en(tx_en), .tx_data(tx_data),
        .full(full), .empty(empty), .count(count), .busy(busy), .sent_pulse(sent_pulse),
        .overflow(overflow), .timeout_err(timeout_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        push = 1;
        push_data = b;
        step();
        push = 0;
    endtask

    // uarttx stand-in: busy from the 3rd cycle after it sees tx_en, for 40 cycles; stuck forces it idle
    int ux = -1;
    always @(posedge clk) begin
        #1;
        if (stuck) ux = -1;
        else if (ux < 0) begin
            if (tx_en) ux = 1;
        end else begin
            ux++;
            if (ux >= 43) ux = -1;
        end
        tx_status = !stuck && ux >= 3;
    end

    // Reference: FIFO as a queue, frame progress as a phase with elapsed-cycle counters
    localparam int P_IDLE = 0, P_REQ = 1, P_XMIT = 2, P_GAP = 3;
    byte unsigned mq[$];
    byte unsigned m_data;
    int ph, waited, gap_left;
    bit m_en, m_sent, m_ovf, m_to, s1, s2, was_full, ovf_new, to_new;
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            ph = P_IDLE; waited = 0; gap_left = 0;
            m_en = 0; m_data = 0; m_sent = 0; m_ovf = 0; m_to = 0; s1 = 0; s2 = 0;
        end else begin
            was_full = mq.size() == DEPTH;
            ovf_new = 0;
            to_new = 0;
            m_sent = 0;
            case (ph)
                P_IDLE: if (enable && mq.size() > 0 && !flush) begin
                    m_data = mq.pop_front(); m_en = 1; waited = 0; ph = P_REQ;
                end
                P_REQ: if (s2) begin
                    m_en = 0; ph = P_XMIT;
                end else if (waited + 1 == TO) begin
                    m_en = 0; to_new = 1; ph = P_IDLE;
                end else waited++;
                P_XMIT: if (!s2) begin
                    m_sent = 1;
                    gap_left = GAP;
                    ph = (GAP > 0) ? P_GAP : P_IDLE;
                end
                default: begin
                    gap_left--;
                    if (gap_left == 0) ph = P_IDLE;
                end
            endcase
            if (flush) mq.delete();
            else if (push) begin
                if (was_full) ovf_new = 1;
                else mq.push_back(push_data);
            end
            m_ovf = ovf_new || (m_ovf && !clr_err);
            m_to = to_new || (m_to && !clr_err);
            s2 = s1;
            s1 = tx_status;
        end
    end

    // Cycle-by-cycle comparison against the reference
    always @(negedge clk) begin
        if (chk_on) begin
            chk("tx_en", tx_en, m_en);
            chk("tx_data", tx_data, m_data);
            chk("count", count, mq.size());
            chk("full", full, mq.size() == DEPTH);
            chk("empty", empty, mq.size() == 0);
            chk("busy", busy, ph != P_IDLE);
            chk("sent_pulse", sent_pulse, m_sent);
            chk("overflow", overflow, m_ovf);
            chk("timeout_err", timeout_err, m_to);
        end
    end

    // Event log used by the hand-computed timing checks
    int cyc = 0, efall_cyc = 0, last_high = 0;
    int rise_q[$], sent_q[$];
    byte unsigned rdata_q[$];
    logic p_en = 0, p_empty = 1;
    always @(negedge clk) begin
        cyc++;
        if (tx_en === 1'b1 && p_en === 1'b0) begin
            rise_q.push_back(cyc);
            rdata_q.push_back(tx_data);
        end
        if (tx_en === 1'b0 && p_en === 1'b1 && rise_q.size() > 0) last_high = cyc - rise_q[rise_q.size()-1];
        if (sent_pulse === 1'b1) sent_q.push_back(cyc);
        if (empty === 1'b0 && p_empty === 1'b1) efall_cyc = cyc;
        p_en = tx_en;
        p_empty = empty;
    end

    int r0, s0;
    initial begin
        step(2);
        reset = 0;
        chk_on = 1;
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_tx_en", tx_en, 0);
        // single byte
        enable = 1;
        r0 = rise_q.size(); s0 = sent_q.size();
        push_byte(8'h55);
        step(70);
        chk("t1_rises", rise_q.size() - r0, 1);
        chk("t1_data", rdata_q[r0], 8'h55);
        chk("t1_latency", rise_q[r0] - efall_cyc, 1);
        chk("t1_sents", sent_q.size() - s0, 1);
        chk("t1_empty", empty, 1);
        chk("t1_busy", busy, 0);
        // fill, overflow, drain across pointer wrap
        enable = 0;
        step(2);
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        chk("t2_full", full, 1);
        chk("t2_count", count, 16);
        push_byte(8'hEE);
        chk("t2_overflow", overflow, 1);
        chk("t2_count_kept", count, 16);
        clr_err = 1; step(); clr_err = 0;
        chk("t2_clr", overflow, 0);
        r0 = rise_q.size(); s0 = sent_q.size();
        enable = 1;
        step(1000);
        chk("t2_rises", rise_q.size() - r0, 16);
        chk("t2_sents", sent_q.size() - s0, 16);
        for (int i = 0; i < 16; i++) chk("t2_order", rdata_q[r0+i], i);
        // start timeout with uarttx never going busy
        stuck = 1;
        step(2);
        r0 = rise_q.size(); s0 = sent_q.size();
        push_byte(8'hA1);
        push_byte(8'hA2);
        step(30);
        chk("t3_rises", rise_q.size() - r0, 2);
        chk("t3_high", last_high, 8);
        chk("t3_spacing", rise_q[r0+1] - rise_q[r0], 9);
        chk("t3_data2", rdata_q[r0+1], 8'hA2);
        chk("t3_sents", sent_q.size() - s0, 0);
        chk("t3_err", timeout_err, 1);
        clr_err = 1; step(); clr_err = 0;
        chk("t3_clr", timeout_err, 0);
        stuck = 0;
        step(5);
        // flush during a frame, with a simultaneous push
        r0 = rise_q.size(); s0 = sent_q.size();
        for (int i = 0; i < 4; i++) push_byte(8'hB0 + 8'(i));
        step(8);
        flush = 1; push = 1; push_data = 8'hFF;
        step();
        flush = 0; push = 0;
        chk("t4_count", count, 0);
        step(80);
        chk("t4_rises", rise_q.size() - r0, 1);
        chk("t4_sents", sent_q.size() - s0, 1);
        chk("t4_data", rdata_q[r0], 8'hB0);
        chk("t4_empty", empty, 1);
        // reset while waiting for the frame to finish
        enable = 0;
        for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i));
        enable = 1;
        step(20);
        chk("t5_busy", busy, 1);
        chk("t5_wait", tx_en, 0);
        reset = 1; step(); reset = 0;
        chk("t5_tx_en", tx_en, 0);
        chk("t5_tx_data", tx_data, 0);
        chk("t5_count", count, 0);
        chk("t5_full", full, 0);
        chk("t5_empty", empty, 1);
        chk("t5_busy0", busy, 0);
        chk("t5_sent", sent_pulse, 0);
        chk("t5_ovf", overflow, 0);
        chk("t5_to", timeout_err, 0);
        r0 = rise_q.size();
        step(100);
        chk("t5_nosend", rise_q.size() - r0, 0);
        // inter-frame gap
        enable = 0;
        push_byte(8'hD1);
        push_byte(8'hD2);
        r0 = rise_q.size(); s0 = sent_q.size();
        enable = 1;
        step(150);
        chk("t6_rises", rise_q.size() - r0, 2);
        chk("t6_sents", sent_q.size() - s0, 2);
        chk("t6_gap", rise_q[r0+1] - sent_q[s0], 6);
        // randomized traffic
        for (int seg = 0; seg < 10; seg++) begin
            stuck = $urandom_range(0, 4) == 0;
            for (int i = 0; i < 200; i++) begin
                push = $urandom_range(0, 99) < 30;
                push_data = 8'($urandom);
                enable = $urandom_range(0, 9) != 0;
                flush = $urandom_range(0, 49) == 0;
                clr_err = $urandom_range(0, 19) == 0;
                reset = $urandom_range(0, 499) == 0;
                step();
            end
        end
        push = 0; flush = 0; clr_err = 0; reset = 0; stuck = 0;
        step(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
